// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Holds the FSM state type, default geometry and the widened MAC product helper.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } sa_state_e;

    localparam int SA_N    = 4;
    localparam int SA_DW   = 16;
    localparam int SA_ACCW = 32;
    // Operands are pre-extended to SA_XW bits so one helper serves any DW <= 32, ACCW <= 64.
    localparam int SA_XW   = 32;
    localparam int SA_PW   = 2 * SA_XW;

    function automatic logic [SA_PW-1:0] ext_mul(input logic [SA_XW-1:0] a,
                                                 input logic [SA_XW-1:0] b,
                                                 input logic             signed_mode);
        logic [SA_PW-1:0] ax;
        logic [SA_PW-1:0] bx;
        ax = {{SA_XW{signed_mode & a[SA_XW-1]}}, a};
        bx = {{SA_XW{signed_mode & b[SA_XW-1]}}, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell: accumulates a*b and forwards a right, b down.
// clr and rst both zero the forwarding registers and the accumulator.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW   = SA_DW,
    parameter int ACCW = SA_ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            signed_mode,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic [DW-1:0]   a_out,
    output logic [DW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);

    logic [SA_XW-1:0] a_x;
    logic [SA_XW-1:0] b_x;
    logic [ACCW-1:0]  prod;

    always_comb begin
        a_x  = {{(SA_XW-DW){signed_mode & a_in[DW-1]}}, a_in};
        b_x  = {{(SA_XW-DW){signed_mode & b_in[DW-1]}}, b_in};
        prod = ACCW'(ext_mul(a_x, b_x, signed_mode));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod;
        end
    end

endmodule

// File: rtl/sa_mm_engine.sv
// N x N output-stationary systolic engine computing C = A*B over a run-time depth K.
// Handshakes: an operand beat moves when a_valid & b_valid & ab_ready; a result row moves when res_valid & res_ready.
module sa_mm_engine
    import sa_pkg::*;
#(
    parameter  int N    = SA_N,
    parameter  int DW   = SA_DW,
    parameter  int ACCW = SA_ACCW,
    parameter  int KMAX = 255,
    localparam int KW   = $clog2(KMAX + 1),
    localparam int RW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              signed_mode,
    output logic              busy,
    input  logic              a_valid,
    input  logic              b_valid,
    input  logic [N*DW-1:0]   a_data,
    input  logic [N*DW-1:0]   b_data,
    output logic              ab_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N*ACCW-1:0] res_row,
    output logic [RW-1:0]     res_row_idx,
    output logic              done,
    output sa_state_e         state_dbg
);

    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
    localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);

    sa_state_e       state_q, state_d;
    logic [KW-1:0]   beats_left;
    logic [FW-1:0]   flush_cnt;
    logic [RW-1:0]   row_idx;
    logic            mode_q;
    logic            done_q;
    logic            beat;
    logic            clr;

    logic [DW-1:0]   inj_a  [N];
    logic [DW-1:0]   inj_b  [N];
    logic [DW-1:0]   a_sk   [N];
    logic [DW-1:0]   b_sk   [N];
    logic [DW-1:0]   a_pipe [N][N+1];
    logic [DW-1:0]   b_pipe [N+1][N];
    logic [ACCW-1:0] acc_w  [N][N];

    assign ab_ready    = (state_q == FEED);
    assign beat        = ab_ready & a_valid & b_valid;
    assign clr         = (state_q == CLEAR);
    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == DRAIN);
    assign res_row_idx = row_idx;
    assign done        = done_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && k_len != '0) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED:    if (beat && beats_left == KW'(1)) state_d = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_d = DRAIN;
            DRAIN:   if (res_ready && row_idx == LAST_ROW) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_left <= '0;
            flush_cnt  <= '0;
            row_idx    <= '0;
            mode_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (k_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            beats_left <= k_len;
                            mode_q     <= signed_mode;
                        end
                    end
                end
                CLEAR: begin
                    flush_cnt <= '0;
                    row_idx   <= '0;
                end
                FEED:  if (beat) beats_left <= beats_left - KW'(1);
                FLUSH: flush_cnt <= flush_cnt + FW'(1);
                DRAIN: begin
                    if (res_ready) begin
                        if (row_idx == LAST_ROW) begin
                            row_idx <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            row_idx <= row_idx + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Anything that is not an accepted beat enters the array as zero, so bubbles and flushes add nothing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inj_a[i] = beat ? a_data[i*DW +: DW] : '0;
            inj_b[i] = beat ? b_data[i*DW +: DW] : '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_d0
            assign a_sk[i] = inj_a[i];
            assign b_sk[i] = inj_b[i];
        end else begin : g_dn
            logic [DW-1:0] sr_a [i];
            logic [DW-1:0] sr_b [i];
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int s = 0; s < i; s++) begin
                        sr_a[s] <= '0;
                        sr_b[s] <= '0;
                    end
                end else begin
                    sr_a[0] <= inj_a[i];
                    sr_b[0] <= inj_b[i];
                    for (int s = 1; s < i; s++) begin
                        sr_a[s] <= sr_a[s-1];
                        sr_b[s] <= sr_b[s-1];
                    end
                end
            end
            assign a_sk[i] = sr_a[i-1];
            assign b_sk[i] = sr_b[i-1];
        end
        assign a_pipe[i][0] = a_sk[i];
        assign b_pipe[0][i] = b_sk[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_pe #(
                .DW  (DW),
                .ACCW(ACCW)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .clr        (clr),
                .signed_mode(mode_q),
                .a_in       (a_pipe[i][j]),
                .b_in       (b_pipe[i][j]),
                .a_out      (a_pipe[i][j+1]),
                .b_out      (b_pipe[i+1][j]),
                .acc        (acc_w[i][j])
            );
        end
    end

    always_comb begin
        res_row = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < N; j++) res_row[j*ACCW +: ACCW] = acc_w[row_idx][j];
        end
    end

endmodule
